// File: rtl/bcd_field_reg.sv
// bcd_field_reg: two-digit BCD time-field register with load, up/down count and wrap at MAX_VAL
// Ports:
//    clk                 rising-edge clock
//    reset               asynchronous active-low reset
//    set, new_tens/units load request and BCD digits to load
//    inc, dec            count-up / count-down enables
//    tens, units         current BCD digits
//    at_max              combinational, field == MAX_VAL
//    carry, borrow       one-cycle pulses after an up wrap / down wrap
//    set_err             one-cycle pulse after a rejected load
module bcd_field_reg #(
   parameter int MAX_VAL   = 59,
   parameter int RESET_VAL = 0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       set,
   input  logic [3:0] new_tens,
   input  logic [3:0] new_units,
   input  logic       inc,
   input  logic       dec,
   output logic [3:0] tens,
   output logic [3:0] units,
   output logic       at_max,
   output logic       carry,
   output logic       borrow,
   output logic       set_err
);
   localparam logic [3:0] MAX_T = 4'(MAX_VAL / 10);
   localparam logic [3:0] MAX_U = 4'(MAX_VAL % 10);
   localparam logic [3:0] RST_T = 4'(RESET_VAL / 10);
   localparam logic [3:0] RST_U = 4'(RESET_VAL % 10);
   logic       at_zero, set_ok;
   logic [3:0] nxt_t, nxt_u;
   logic       nxt_c, nxt_b, nxt_e;
   assign at_max  = tens == MAX_T && units == MAX_U;
   assign at_zero = tens == 4'd0 && units == 4'd0;
   // with both digits legal BCD, concatenated digits compare like the decimal value
   assign set_ok  = new_tens <= 4'd9 && new_units <= 4'd9 && {new_tens, new_units} <= {MAX_T, MAX_U};
   always_comb begin
      nxt_t = tens;
      nxt_u = units;
      nxt_c = 1'b0;
      nxt_b = 1'b0;
      nxt_e = 1'b0;
      if (set) begin
         if (set_ok) begin
            nxt_t = new_tens;
            nxt_u = new_units;
         end else begin
            nxt_e = 1'b1;
         end
      end else if (inc && !dec) begin
         if (at_max) begin
            nxt_t = 4'd0;
            nxt_u = 4'd0;
            nxt_c = 1'b1;
         end else if (units == 4'd9) begin
            nxt_u = 4'd0;
            nxt_t = tens + 4'd1;
         end else begin
            nxt_u = units + 4'd1;
         end
      end else if (dec && !inc) begin
         if (at_zero) begin
            nxt_t = MAX_T;
            nxt_u = MAX_U;
            nxt_b = 1'b1;
         end else if (units == 4'd0) begin
            nxt_u = 4'd9;
            nxt_t = tens - 4'd1;
         end else begin
            nxt_u = units - 4'd1;
         end
      end
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tens    <= RST_T;
         units   <= RST_U;
         carry   <= 1'b0;
         borrow  <= 1'b0;
         set_err <= 1'b0;
      end else begin
         tens    <= nxt_t;
         units   <= nxt_u;
         carry   <= nxt_c;
         borrow  <= nxt_b;
         set_err <= nxt_e;
      end
   end
endmodule

// File: doc/bcd_field_reg.md
Name: bcd_field_reg

Overview:
- Parametrised two-digit BCD time-field register: the successor to the single-digit seconds register.
- One instance holds a full seconds or minutes field (MAX_VAL=59) or an hours field (MAX_VAL=23).
- Supports load, count up and count down, with wrap at a programmable maximum.
- Instances chain through the carry/borrow pulses into the clock datapath.

Parameters:
- MAX_VAL, 59: largest legal field value, decimal, range 1..99. The count wraps MAX_VAL->0 and 0->MAX_VAL.
- RESET_VAL, 0: value loaded on reset, decimal. Must be <= MAX_VAL.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset. reset=0 forces reset state immediately.
- set  in  1  load request, sampled on the clock edge.
- new_tens  in  4  BCD tens digit to load.
- new_units  in  4  BCD units digit to load.
- inc  in  1  count-up enable: +1 per edge while high.
- dec  in  1  count-down enable: -1 per edge while high.
- tens  out  4  current tens digit (BCD).
- units  out  4  current units digit (BCD).
- at_max  out  1  combinational; 1 when the field value == MAX_VAL.
- carry  out  1  registered one-cycle pulse, 1 the cycle after an inc wrap MAX_VAL->0.
- borrow  out  1  registered one-cycle pulse, 1 the cycle after a dec wrap 0->MAX_VAL.
- set_err  out  1  registered one-cycle pulse, 1 the cycle after a rejected set.

Behaviour:
- Reset (reset=0, async):
  - tens = RESET_VAL/10; units = RESET_VAL%10.
  - carry = borrow = set_err = 0.
  - Reset asserted mid-count aborts the count and clears any pending pulse. The first edge after release acts normally.
- Priority at each edge: set > (inc and dec both high) > inc > dec > hold.
- set=1:
  - Valid when new_tens <= 9, new_units <= 9 and 10*new_tens + new_units <= MAX_VAL.
  - Valid load: the field takes the new value at the edge, with latency 1 (visible after the edge).
  - Invalid load: the field holds and set_err = 1 for the next cycle.
  - inc/dec are ignored in a set cycle. No carry or borrow is produced.
- inc=1 and dec=1 together (no set): field holds; no pulses.
- inc only:
  - units < 9 and value != MAX_VAL: units+1.
  - units == 9 and value != MAX_VAL: units = 0, tens+1.
  - value == MAX_VAL: tens = units = 0, and carry = 1 for exactly the next cycle.
- dec only:
  - units > 0: units-1.
  - units == 0 and value != 0: units = 9, tens-1.
  - value == 0: load MAX_VAL digits, and borrow = 1 for exactly the next cycle.
- Continuous inc or dec: counts every cycle. Back-to-back wraps produce separate single-cycle pulses.
- A wrap edge can be followed directly by a set edge. The pulse from the wrap still appears for its one cycle.
- Outputs never show a non-BCD digit or a value > MAX_VAL after reset.
- at_max is decoded from the registered digits, with no added latency.
- carry, borrow and set_err are 0 in every cycle where their condition did not occur at the previous edge.

Test Plan:
- MAX_VAL=59: hold reset=0 -> tens=0, units=0, all pulses 0. Release reset, set with 5/7 -> 57 after 1 edge, at_max=0.
- MAX_VAL=59: from 57, inc high for 3 edges -> 58, 59 (at_max=1), 00. carry=1 for only the cycle after the 59->00 edge.
- MAX_VAL=59: set 0/9, then inc -> 10. Then dec for 2 edges -> 09, 08. Then dec from 00 -> 59 with a borrow pulse of one cycle.
- MAX_VAL=23: set 2/4 -> field holds its previous value, set_err pulses once. Set 1/12 (non-BCD) -> set_err again. Set 2/3, then inc -> 00 with carry.
- Priority: at 14, drive set(2/0)+inc -> 20 with no carry. Then inc+dec together -> stays 20.
- Async reset: at 59 assert inc, then drop reset to 0 mid-cycle -> output 00 before the next edge. carry stays 0 after release.
